seg7_scan_ctrl: RTL and testbench



---
 rtl/seg7_scan_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_ctrl
// Brief    : Four-digit multiplexed seven-segment driver with tear-free
//            data update and an all-anodes-off guard after each digit step.
// Options  : LEADING_ZERO_BLANK_EN - blank leading zero digits (digit 0 kept)
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_ctrl #(
    parameter int GUARD_CYCLES = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic        in_clk,
    input  logic        reset_clk,
    input  logic        scan_clk,
    input  logic        enable,
    input  logic [15:0] data_in,
    input  logic        data_valid,
    input  logic [3:0]  dp_in,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [1:0]  digit_sel
);

    localparam logic [1:0] c_ST_OFF   = 2'd0;
    localparam logic [1:0] c_ST_GUARD = 2'd1;
    localparam logic [1:0] c_ST_SHOW  = 2'd2;

    localparam logic [7:0] c_GUARD_LAST = 8'(GUARD_CYCLES - 1);
    localparam logic [6:0] c_SEG_OFF    = 7'h7F;

    // ------------------------------------------------------------------
    // scan_clk synchronizer and dual-edge detector
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_scan_sync;
    logic                   r_scan_prev;
    logic                   w_step;

    always_ff @(posedge in_clk or posedge reset_clk) begin
        if (reset_clk) begin
            r_scan_sync <= '0;
            r_scan_prev <= 1'b0;
        end else begin
            r_scan_sync <= {r_scan_sync[SYNC_STAGES-2:0], scan_clk};
            r_scan_prev <= r_scan_sync[SYNC_STAGES-1];
        end
    end

    assign w_step = r_scan_sync[SYNC_STAGES-1] ^ r_scan_prev;

    // ------------------------------------------------------------------
    // Scan state machine
    // ------------------------------------------------------------------
    logic [1:0]  r_state;
    logic [7:0]  r_count;
    logic [1:0]  r_digit_sel;
    logic [1:0]  w_state_nx;
    logic [7:0]  w_count_nx;
    logic [1:0]  w_sel_nx;
    logic        w_step_take;
    logic        w_wrap;

    assign w_step_take = enable && (r_state != c_ST_OFF) && w_step;

    always_comb begin
        w_state_nx = r_state;
        w_count_nx = r_count;
        w_sel_nx   = r_digit_sel;
        w_wrap     = 1'b0;
        if (!enable) begin
            w_state_nx = c_ST_OFF;
        end else if (w_step_take) begin
            // A step always wins, even on the last guard cycle, so none is lost.
            w_wrap     = (r_digit_sel == 2'd3);
            w_sel_nx   = r_digit_sel + 2'd1;
            w_state_nx = c_ST_GUARD;
            w_count_nx = 8'd0;
        end else begin
            case (r_state)
                c_ST_OFF: begin
                    w_state_nx = c_ST_GUARD;
                    w_count_nx = 8'd0;
                end
                c_ST_GUARD: begin
                    if (r_count == c_GUARD_LAST) begin
                        w_state_nx = c_ST_SHOW;
                    end else begin
                        w_count_nx = r_count + 8'd1;
                    end
                end
                c_ST_SHOW: begin
                    w_state_nx = c_ST_SHOW;
                end
                default: begin
                    w_state_nx = c_ST_GUARD;
                    w_count_nx = 8'd0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Shadow / display registers: {dp[3:0], nibbles[15:0]}
    // ------------------------------------------------------------------
    logic [19:0] r_shadow;
    logic [19:0] r_disp;
    logic        r_pend;
    logic [19:0] w_shadow_nx;
    logic [19:0] w_disp_nx;
    logic        w_pend_nx;

    always_comb begin
        w_shadow_nx = data_valid ? {dp_in, data_in} : r_shadow;
        w_pend_nx   = r_pend | data_valid;
        w_disp_nx   = r_disp;
        // Transfer only at frame boundaries (or while dark) to avoid tearing.
        if (r_state == c_ST_OFF) begin
            if (w_pend_nx) begin
                w_disp_nx = w_shadow_nx;
            end
            w_pend_nx = 1'b0;
        end else if (w_wrap && w_pend_nx) begin
            w_disp_nx = w_shadow_nx;
            w_pend_nx = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Output pattern, computed from next-state so it is registered in time
    // ------------------------------------------------------------------
    function automatic logic [6:0] seg7_decode(input logic [3:0] nib);
        logic [6:0] v;
        case (nib)
            4'h0:    v = 7'h40;
            4'h1:    v = 7'h79;
            4'h2:    v = 7'h24;
            4'h3:    v = 7'h30;
            4'h4:    v = 7'h19;
            4'h5:    v = 7'h12;
            4'h6:    v = 7'h02;
            4'h7:    v = 7'h78;
            4'h8:    v = 7'h00;
            4'h9:    v = 7'h10;
            4'hA:    v = 7'h08;
            4'hB:    v = 7'h03;
            4'hC:    v = 7'h46;
            4'hD:    v = 7'h21;
            4'hE:    v = 7'h06;
            default: v = 7'h0E;
        endcase
        return v;
    endfunction

    logic [3:0] w_nibble;
    logic [3:0] w_disp_dp;
    logic       w_blank;
    logic       w_show_nx;
    logic [3:0] w_an_nx;
    logic [6:0] w_seg_nx;
    logic       w_dp_nx;

    assign w_nibble  = w_disp_nx[{w_sel_nx, 2'b00} +: 4];
    assign w_disp_dp = w_disp_nx[19:16];
    assign w_show_nx = (w_state_nx == c_ST_SHOW);

`ifdef LEADING_ZERO_BLANK_EN
    assign w_blank = (w_sel_nx != 2'd0) &&
                     ((w_disp_nx[15:0] >> {w_sel_nx, 2'b00}) == 16'd0);
`else
    assign w_blank = 1'b0;
`endif

    always_comb begin
        w_an_nx  = 4'hF;
        w_seg_nx = c_SEG_OFF;
        w_dp_nx  = 1'b1;
        if (w_show_nx) begin
            w_an_nx  = ~(4'b0001 << w_sel_nx);
            w_seg_nx = w_blank ? c_SEG_OFF : seg7_decode(w_nibble);
            w_dp_nx  = ~w_disp_dp[w_sel_nx];
        end
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    logic [3:0] r_an;
    logic [6:0] r_seg;
    logic       r_dp;

    always_ff @(posedge in_clk or posedge reset_clk) begin
        if (reset_clk) begin
            r_state     <= c_ST_GUARD;
            r_count     <= 8'd0;
            r_digit_sel <= 2'd0;
            r_shadow    <= 20'd0;
            r_disp      <= 20'd0;
            r_pend      <= 1'b0;
            r_an        <= 4'hF;
            r_seg       <= c_SEG_OFF;
            r_dp        <= 1'b1;
        end else begin
            r_state     <= w_state_nx;
            r_count     <= w_count_nx;
            r_digit_sel <= w_sel_nx;
            r_shadow    <= w_shadow_nx;
            r_disp      <= w_disp_nx;
            r_pend      <= w_pend_nx;
            r_an        <= w_an_nx;
            r_seg       <= w_seg_nx;
            r_dp        <= w_dp_nx;
        end
    end

    assign an        = r_an;
    assign seg       = r_seg;
    assign dp        = r_dp;
    assign digit_sel = r_digit_sel;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan_ctrl
// Brief    : Directed bench for seg7_scan_ctrl with a cycle-level reference
//            model; honours LEADING_ZERO_BLANK_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_ctrl;

    localparam int c_GUARD = 16;
    localparam int c_SYNC  = 2;
    localparam int c_M_OFF   = 0;
    localparam int c_M_GUARD = 1;
    localparam int c_M_SHOW  = 2;
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit c_BLANK = 1'b1;
`else
    localparam bit c_BLANK = 1'b0;
`endif

    logic        in_clk = 1'b0;
    logic        reset_clk;
    logic        scan_clk;
    logic        enable;
    logic [15:0] data_in;
    logic        data_valid;
    logic [3:0]  dp_in;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [1:0]  digit_sel;

    int checks   = 0;
    int failures = 0;

    seg7_scan_ctrl #(.GUARD_CYCLES(c_GUARD), .SYNC_STAGES(c_SYNC)) dut (
        .in_clk     (in_clk),
        .reset_clk  (reset_clk),
        .scan_clk   (scan_clk),
        .enable     (enable),
        .data_in    (data_in),
        .data_valid (data_valid),
        .dp_in      (dp_in),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .digit_sel  (digit_sel)
    );

    always #5 in_clk = ~in_clk;

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int          m_mode   = c_M_GUARD;
    int          m_cnt    = 0;
    int          m_sel    = 0;
    logic [19:0] m_disp   = '0;
    logic [19:0] m_shadow = '0;
    bit          m_pend   = 1'b0;
    logic [7:0]  m_hist   = '0;
    logic [3:0]  e_an  = 4'hF;
    logic [6:0]  e_seg = 7'h7F;
    logic        e_dp  = 1'b1;

    task automatic model_step();
        bit          step;
        bit          wrap;
        int          old_mode;
        logic [19:0] newv;
        logic [3:0]  nib;
        if (reset_clk) begin
            m_mode = c_M_GUARD; m_cnt = 0; m_sel = 0;
            m_disp = '0; m_shadow = '0; m_pend = 0; m_hist = '0;
        end else begin
            // an edge seen at this clock was sampled c_SYNC clocks earlier
            step     = (m_hist[c_SYNC-1] != m_hist[c_SYNC]);
            m_hist   = {m_hist[6:0], scan_clk};
            old_mode = m_mode;
            wrap     = 0;
            newv     = {dp_in, data_in};
            if (!enable) begin
                m_mode = c_M_OFF;
            end else if (old_mode == c_M_OFF) begin
                m_mode = c_M_GUARD; m_cnt = 0;
            end else if (step) begin
                wrap   = (m_sel == 3);
                m_sel  = (m_sel + 1) % 4;
                m_mode = c_M_GUARD;
                m_cnt  = 0;
            end else if (m_mode == c_M_GUARD) begin
                if (m_cnt == c_GUARD - 1) m_mode = c_M_SHOW;
                else m_cnt++;
            end
            if (old_mode == c_M_OFF) begin
                if (data_valid) begin m_disp = newv; m_shadow = newv; end
                else if (m_pend) m_disp = m_shadow;
                m_pend = 0;
            end else begin
                if (data_valid) begin m_shadow = newv; m_pend = 1; end
                if (wrap && m_pend) begin m_disp = m_shadow; m_pend = 0; end
            end
        end
        e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
        if (m_mode == c_M_SHOW) begin
            e_an[m_sel] = 1'b0;
            nib   = 4'((m_disp[15:0] >> (4 * m_sel)) & 16'hF);
            e_seg = seg_tab[nib];
            if (c_BLANK && m_sel > 0 && (m_disp[15:0] >> (4 * m_sel)) == 16'd0) e_seg = 7'h7F;
            e_dp  = ~m_disp[16 + m_sel];
        end
    endtask

    initial forever begin
        @(posedge in_clk or posedge reset_clk);
        model_step();
    end

    initial forever begin
        @(posedge in_clk);
        #1;
        checks++;
        if (an !== e_an || seg !== e_seg || dp !== e_dp || digit_sel !== 2'(m_sel)) begin
            failures++;
            $display("FAIL cycle_cmp t=%0t an=%h/%h seg=%h/%h dp=%b/%b sel=%0d/%0d (actual/required)",
                     $time, an, e_an, seg, e_seg, dp, e_dp, digit_sel, m_sel);
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus with literal expectations
    // ------------------------------------------------------------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge in_clk);
    endtask

    task automatic toggle_scan(input int gap);
        @(negedge in_clk);
        scan_clk = ~scan_clk;
        wait_cyc(gap);
    endtask

    task automatic load(input logic [15:0] v, input logic [3:0] d);
        @(negedge in_clk);
        data_in = v; dp_in = d; data_valid = 1'b1;
        @(negedge in_clk);
        data_valid = 1'b0;
    endtask

    initial begin
        reset_clk = 1'b1; enable = 1'b1; scan_clk = 1'b0;
        data_in = '0; dp_in = '0; data_valid = 1'b0;
        wait_cyc(3);
        chk("rst_an", an, 4'hF);
        chk("rst_seg", seg, 7'h7F);
        chk("rst_dp", dp, 1'b1);
        chk("rst_sel", digit_sel, 2'd0);
        reset_clk = 1'b0;

        // power-up guard then digit 0 of the zero display
        repeat (15) @(posedge in_clk);
        #1 chk("guard_an", an, 4'hF);
        @(posedge in_clk);
        #1 chk("first_an", an, 4'hE);
        chk("first_seg", seg, 7'h40);

        // 16'h12AF appears only after the wrap
        load(16'h12AF, 4'h0);
        repeat (4) toggle_scan(1000);
        chk("d0_an", an, 4'hE);   chk("d0_seg", seg, 7'h0E);
        toggle_scan(1000);
        chk("d1_an", an, 4'hD);   chk("d1_seg", seg, 7'h08);
        toggle_scan(1000);
        chk("d2_an", an, 4'hB);   chk("d2_seg", seg, 7'h24);
        toggle_scan(1000);
        chk("d3_an", an, 4'h7);   chk("d3_seg", seg, 7'h79);

        // mid-scan load held back until the next frame
        toggle_scan(200);
        toggle_scan(200);
        load(16'h0001, 4'h0);
        wait_cyc(5);
        chk("mid_d1_seg", seg, 7'h08);
        toggle_scan(200);
        chk("mid_d2_seg", seg, 7'h24);
        toggle_scan(200);
        chk("mid_d3_seg", seg, 7'h79);
        toggle_scan(200);
        chk("new_d0_an", an, 4'hE);
        chk("new_d0_seg", seg, 7'h79);

        // load coinciding with the wrap step goes straight to display
        repeat (3) toggle_scan(200);
        @(negedge in_clk);
        scan_clk = ~scan_clk;
        @(negedge in_clk);
        @(negedge in_clk);
        data_in = 16'h8888; dp_in = 4'b0001; data_valid = 1'b1;
        @(negedge in_clk);
        data_valid = 1'b0;
        repeat (15) @(posedge in_clk);
        #1 chk("same_guard_an", an, 4'hF);
        @(posedge in_clk);
        #1 chk("same_an", an, 4'hE);
        chk("same_seg", seg, 7'h00);
        chk("same_dp", dp, 1'b0);

        // disable freezes the scan; a load while dark lands at once
        wait_cyc(20);
        @(negedge in_clk);
        enable = 1'b0;
        @(posedge in_clk);
        #1 chk("off_an", an, 4'hF);
        chk("off_seg", seg, 7'h7F);
        repeat (3) toggle_scan(20);
        load(16'h3456, 4'h0);
        wait_cyc(5);
        chk("off_sel", digit_sel, 2'd0);
        @(negedge in_clk);
        enable = 1'b1;
        repeat (16) @(posedge in_clk);
        #1 chk("reen_guard_an", an, 4'hF);
        @(posedge in_clk);
        #1 chk("reen_an", an, 4'hE);
        chk("reen_seg", seg, 7'h02);

        // asynchronous reset during the guard before digit 2
        toggle_scan(200);
        toggle_scan(0);
        wait_cyc(8);
        chk("pre_rst_sel", digit_sel, 2'd2);
        chk("pre_rst_an", an, 4'hF);
        #2 reset_clk = 1'b1;
        #1 chk("arst_sel", digit_sel, 2'd0);
        chk("arst_an", an, 4'hF);
        chk("arst_seg", seg, 7'h7F);
        scan_clk = 1'b0;
        wait_cyc(3);
        reset_clk = 1'b0;
        repeat (15) @(posedge in_clk);
        #1 chk("post_rst_guard_an", an, 4'hF);
        @(posedge in_clk);
        #1 chk("post_rst_an", an, 4'hE);
        chk("post_rst_seg", seg, 7'h40);

        // leading zero handling on 16'h0040
        load(16'h0040, 4'h0);
        repeat (4) toggle_scan(200);
        chk("lz_d0_seg", seg, 7'h40);
        toggle_scan(200);
        chk("lz_d1_seg", seg, 7'h19);
        toggle_scan(200);
        chk("lz_d2_an", an, 4'hB);
        chk("lz_d2_seg", seg, c_BLANK ? 7'h7F : 7'h40);
        toggle_scan(200);
        chk("lz_d3_seg", seg, c_BLANK ? 7'h7F : 7'h40);

        wait_cyc(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
